// File: rtl/ctrl_uart_pkg.sv
// Constants and byte-FSM encoding shared by the framed UART transmitter and receiver.
package ctrl_uart_pkg;

  localparam int CLKS_PER_BIT  = 434;   // 50 MHz / 115200 baud
  localparam int PAYLOAD_BYTES = 12;
  localparam int DATA_W        = 8 * PAYLOAD_BYTES;
  localparam int GAP_BITS      = 20;
  localparam logic [7:0] TRAILER = 8'hF0;

  typedef enum logic [1:0] {
    URX_IDLE,
    URX_START,
    URX_DATA,
    URX_STOP
  } urx_state_t;

endpackage

// File: rtl/ctrl_uart_rx_urx.sv
// Byte-level 8N1 receiver: rx synchroniser, baud counter and start/data/stop FSM.
module urx
  import ctrl_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = ctrl_uart_pkg::CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       idle
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta;
  logic             rx_s;
  urx_state_t       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic             break_wait;

  // NOTE: the synchroniser presets to 1 so reset release looks like an idle line,
  // not a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: strobes default low at the top of the block and are raised below; with
  // non-blocking assignments the last assignment in program order wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= URX_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      break_wait <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (state)
        URX_IDLE: begin
          baud_cnt <= '0;
          if (!rx_s) state <= URX_START;
        end
        URX_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= rx_s ? URX_IDLE : URX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        URX_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt  <= '0;
            byte_data <= {rx_s, byte_data[7:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= URX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        URX_STOP: begin
          // After a bad stop bit, hold here until the line recovers so a break
          // is not mistaken for a new start bit.
          if (break_wait) begin
            if (rx_s) begin
              break_wait <= 1'b0;
              state      <= URX_IDLE;
            end
          end else if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (rx_s) begin
              byte_valid <= 1'b1;
              state      <= URX_IDLE;
            end else begin
              byte_err   <= 1'b1;
              break_wait <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= URX_IDLE;
      endcase
    end
  end

  assign idle = (state == URX_IDLE);

endmodule

// File: rtl/ctrl_uart_rx.sv
// Framed UART receiver: assembles 12 payload bytes plus trailer into a 96-bit word,
// with gap timeout and frame error reporting.
module ctrl_uart_rx
  import ctrl_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = ctrl_uart_pkg::CLKS_PER_BIT,
  parameter int GAP_BITS     = ctrl_uart_pkg::GAP_BITS
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_CNT = 4'(PAYLOAD_BYTES);

  logic [7:0]        rx_byte;
  logic              byte_valid;
  logic              byte_err;
  logic              urx_idle;
  logic [3:0]        byte_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [GAP_W-1:0]  gap_cnt;

  urx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_urx (
    .clk       (clk_50),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_data (rx_byte),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .idle      (urx_idle)
  );

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      data      <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      byte_cnt  <= '0;
      shift_reg <= '0;
      gap_cnt   <= '0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;

      // Gap counter only runs between bytes of a partially received frame.
      if (byte_cnt != '0 && urx_idle) begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt   <= '0;
          frame_err <= 1'b1;
          byte_cnt  <= '0;
          busy      <= 1'b0;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end else begin
        gap_cnt <= '0;
      end

      if (byte_err) begin
        frame_err <= 1'b1;
        byte_cnt  <= '0;
        busy      <= 1'b0;
      end

      // A completed byte takes priority over a simultaneous gap expiry.
      if (byte_valid) begin
        frame_err <= 1'b0;
        if (byte_cnt < LAST_CNT) begin
          shift_reg <= {shift_reg[DATA_W-9:0], rx_byte};
          byte_cnt  <= byte_cnt + 1'b1;
          busy      <= 1'b1;
        end else begin
          byte_cnt <= '0;
          busy     <= 1'b0;
          if (rx_byte == TRAILER) begin
            data  <= shift_reg;
            valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrl_uart_rx.sv
// Directed bench for ctrl_uart_rx with a payload scoreboard, run at a reduced baud divisor.
module tb_ctrl_uart_rx;
  import ctrl_uart_pkg::*;

  localparam int CPB = 16;
  localparam int GAP = 20;

  logic              clk_50 = 1'b0;
  logic              rst_n  = 1'b0;
  logic              rx     = 1'b1;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              busy;
  logic              frame_err;

  int compared   = 0;
  int mismatched = 0;
  int valid_cnt  = 0;
  int ferr_cnt   = 0;
  logic busy_seen = 1'b0;
  logic [DATA_W-1:0] sb_q[$];

  ctrl_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .GAP_BITS    (GAP)
  ) u_dut (
    .clk_50   (clk_50),
    .rst_n    (rst_n),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #10 clk_50 = ~clk_50;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on valid, pulse counting, exclusivity.
  always @(negedge clk_50) begin
    if (busy) busy_seen = 1'b1;
    if (valid || frame_err) check("valid_ferr_exclusive", valid & frame_err, '0);
    if (frame_err) ferr_cnt++;
    if (valid) begin
      valid_cnt++;
      if (sb_q.size() > 0) check("sb_data", data, sb_q.pop_front());
      else check("sb_unexpected_valid", valid, 1'b0);
    end
  end

  task automatic wait_bits(input int n);
    repeat (n * CPB) @(negedge clk_50);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_bits(1);
    end
    rx = stop_bit;
    wait_bits(1);
    rx = 1'b1;
  endtask

  task automatic send_payload(input logic [DATA_W-1:0] p, input int nbytes);
    for (int k = 0; k < nbytes; k++) send_byte(p[DATA_W-1-8*k -: 8], 1'b1);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] p, input logic [7:0] trailer);
    send_payload(p, PAYLOAD_BYTES);
    send_byte(trailer, 1'b1);
  endtask

  initial begin
    logic [DATA_W-1:0] p1, p2, p3, p4, p5, p6, p7;
    int v0, f0, cyc;
    p1 = 96'h0102030405060708090A0B0C;
    p2 = {12{8'hAA}};
    p3 = 96'hDEADBEEF_12345678_C0FFEE55;
    p4 = 96'h8001_7FFE_00FF_FF00_5AA5_0F0F;
    p5 = 96'hF0F0F0F0_0000_0001_80000000;
    p6 = 96'h1122334455667788_99AABBCC;
    p7 = 96'hFEDCBA98_76543210_0123ABCD;

    // Reset state
    repeat (5) @(negedge clk_50);
    check("rst_data", data, '0);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    rst_n = 1'b1;
    wait_bits(2);

    // Good frame 01..0C, F0
    v0 = valid_cnt; f0 = ferr_cnt;
    sb_q.push_back(p1);
    send_frame(p1, TRAILER);
    wait_bits(2);
    check("f1_valid_pulses", 96'(valid_cnt - v0), 96'd1);
    check("f1_no_ferr", 96'(ferr_cnt - f0), 96'd0);
    check("f1_data", data, p1);
    check("f1_busy_low", busy, 1'b0);

    // Bad trailer: error, no valid, data held; then AA frame
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(p1, 8'hF1);
    wait_bits(2);
    check("badtrl_ferr", 96'(ferr_cnt - f0), 96'd1);
    check("badtrl_no_valid", 96'(valid_cnt - v0), 96'd0);
    check("badtrl_data_held", data, p1);
    sb_q.push_back(p2);
    send_frame(p2, TRAILER);
    wait_bits(2);
    check("aa_data", data, p2);
    check("aa_valid", 96'(valid_cnt - v0), 96'd1);

    // Gap timeout after 5 bytes
    f0 = ferr_cnt;
    send_payload(p4, 5);
    check("gap_busy_high", busy, 1'b1);
    cyc = 0;
    while (ferr_cnt == f0 && cyc < 30 * CPB) begin
      @(negedge clk_50);
      cyc++;
    end
    check("gap_fired", 96'(ferr_cnt - f0), 96'd1);
    check("gap_timing", (cyc >= 19 * CPB - 4) && (cyc <= 20 * CPB + 4), 1'b1);
    @(negedge clk_50);
    check("gap_busy_low", busy, 1'b0);
    wait_bits(5);
    v0 = valid_cnt;
    sb_q.push_back(p3);
    send_frame(p3, TRAILER);
    wait_bits(2);
    check("gap_next_valid", 96'(valid_cnt - v0), 96'd1);
    check("gap_next_data", data, p3);

    // Bad stop bit on third byte
    f0 = ferr_cnt;
    send_payload(p5, 2);
    send_byte(8'h3C, 1'b0);
    wait_bits(1);
    check("stop_ferr", 96'(ferr_cnt - f0), 96'd1);
    check("stop_busy_low", busy, 1'b0);
    v0 = valid_cnt;
    sb_q.push_back(p4);
    send_frame(p4, TRAILER);
    wait_bits(2);
    check("stop_next_valid", 96'(valid_cnt - v0), 96'd1);
    check("stop_next_data", data, p4);

    // Short low glitch on idle line
    v0 = valid_cnt; f0 = ferr_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk_50);
    rx = 1'b1;
    wait_bits(GAP + 2);
    check("glitch_no_valid", 96'(valid_cnt - v0), 96'd0);
    check("glitch_no_ferr", 96'(ferr_cnt - f0), 96'd0);
    check("glitch_busy", busy_seen, 1'b0);

    // Back-to-back frames with no idle between them
    v0 = valid_cnt;
    sb_q.push_back(p6);
    sb_q.push_back(p7);
    send_frame(p6, TRAILER);
    send_frame(p7, TRAILER);
    wait_bits(2);
    check("b2b_valids", 96'(valid_cnt - v0), 96'd2);
    check("b2b_data", data, p7);

    // Reset after 7 bytes, then a fresh frame
    send_payload(p6, 7);
    rst_n = 1'b0;
    repeat (5) @(negedge clk_50);
    check("mrst_data", data, '0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_valid", valid, 1'b0);
    check("mrst_ferr", frame_err, 1'b0);
    rst_n = 1'b1;
    wait_bits(1);
    v0 = valid_cnt; f0 = ferr_cnt;
    sb_q.push_back(p5);
    send_frame(p5, TRAILER);
    wait_bits(2);
    check("mrst_new_valid", 96'(valid_cnt - v0), 96'd1);
    check("mrst_new_data", data, p5);
    check("mrst_no_ferr", 96'(ferr_cnt - f0), 96'd0);
    check("sb_drained", 96'(sb_q.size()), 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
